rw_command_sequencer: RTL and testbench

//  Bus-side front end of the PIC, directly upstream of Control_Logic.
//  - Synchronises the CPU strobes cs_n/wr_n/rd_n/a0 and captures write data.
//  - Tracks the ICW1->ICW2->[ICW3]->[ICW4] initialisation sequence.
//  - Drives FlagFromRW (rw_flag), ReadWriteinputData (rw_data) and read2controlRW (read_sel).

---
 rtl/rw_command_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rw_command_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rw_command_sequencer.sv
// Bus-side front end of the PIC: synchronises CPU strobes, tracks the ICW sequence and
// emits command codes to Control_Logic. Optional poll command: define RW_POLL_CMD_EN.
module rw_command_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic [7:0] rw_data,
  output logic [2:0] rw_flag,
  output logic [2:0] read_sel,
  output logic       init_done,
  output logic       sngl,
  output logic       ic4,
  output logic       illegal_wr
);

  localparam logic [2:0] F_ICW1 = 3'd0, F_ICW2 = 3'd1, F_ICW3 = 3'd2, F_ICW4 = 3'd3;
  localparam logic [2:0] F_OCW1 = 3'd4, F_OCW2 = 3'd5, F_OCW3 = 3'd6, F_IDLE = 3'd7;

  typedef enum logic [2:0] {
    WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, wr_sync_q, rd_sync_q;
  logic cs_s, wr_s, rd_s;
  logic wr_prev_q, cs_prev_q, seen_low_q, wr_commit;
  logic       hold_a_q;
  logic [7:0] hold_d_q;

  state_e     state_q;
  logic [7:0] rw_data_q;
  logic [2:0] rw_flag_q;
  logic       init_done_q, sngl_q, ic4_q, illegal_q, ris_q;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];

  // The wr chain resets low so a strobe held low across reset release never
  // shows a falling edge and therefore never arms seen_low_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      rd_sync_q  <= '1;
      wr_sync_q  <= '0;
      wr_prev_q  <= 1'b0;
      cs_prev_q  <= 1'b1;
      seen_low_q <= 1'b0;
      hold_a_q   <= 1'b0;
      hold_d_q   <= '0;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_n};
      wr_prev_q <= wr_s;
      cs_prev_q <= cs_s;
      if (wr_prev_q && !wr_s) seen_low_q <= 1'b1;
      else if (wr_s)          seen_low_q <= 1'b0;
      if (!wr_s && !cs_s) begin
        hold_a_q <= a0;
        hold_d_q <= data_in;
      end
    end
  end

  assign wr_commit = wr_s && !wr_prev_q && seen_low_q && !cs_prev_q;

`ifdef RW_POLL_CMD_EN
  logic poll_pending_q, poll_rd_q, rd_prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_rd_q <= 1'b0;
      rd_prev_q <= 1'b1;
    end else begin
      poll_rd_q <= (read_sel == 3'b111);
      rd_prev_q <= rd_s;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_ICW1;
      rw_data_q   <= '0;
      rw_flag_q   <= F_IDLE;
      init_done_q <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      illegal_q   <= 1'b0;
      ris_q       <= 1'b0;
`ifdef RW_POLL_CMD_EN
      poll_pending_q <= 1'b0;
`endif
    end else begin
      rw_flag_q <= F_IDLE;
      illegal_q <= 1'b0;
`ifdef RW_POLL_CMD_EN
      if (rd_s && !rd_prev_q && poll_rd_q) poll_pending_q <= 1'b0;
`endif
      if (wr_commit) begin
        if (!hold_a_q && hold_d_q[4]) begin
          rw_flag_q   <= F_ICW1;
          rw_data_q   <= hold_d_q;
          sngl_q      <= hold_d_q[1];
          ic4_q       <= hold_d_q[0];
          init_done_q <= 1'b0;
          ris_q       <= 1'b0;
`ifdef RW_POLL_CMD_EN
          poll_pending_q <= 1'b0;
`endif
          state_q     <= WAIT_ICW2;
        end else begin
          case (state_q)
            WAIT_ICW2: begin
              if (hold_a_q) begin
                rw_flag_q <= F_ICW2;
                rw_data_q <= hold_d_q;
                if (!sngl_q)    state_q <= WAIT_ICW3;
                else if (ic4_q) state_q <= WAIT_ICW4;
                else begin
                  state_q     <= READY;
                  init_done_q <= 1'b1;
                end
              end else illegal_q <= 1'b1;
            end
            WAIT_ICW3: begin
              if (hold_a_q) begin
                rw_flag_q <= F_ICW3;
                rw_data_q <= hold_d_q;
                if (ic4_q) state_q <= WAIT_ICW4;
                else begin
                  state_q     <= READY;
                  init_done_q <= 1'b1;
                end
              end else illegal_q <= 1'b1;
            end
            WAIT_ICW4: begin
              if (hold_a_q) begin
                rw_flag_q   <= F_ICW4;
                rw_data_q   <= hold_d_q;
                state_q     <= READY;
                init_done_q <= 1'b1;
              end else illegal_q <= 1'b1;
            end
            READY: begin
              rw_data_q <= hold_d_q;
              if (hold_a_q) rw_flag_q <= F_OCW1;
              else if (!hold_d_q[3]) rw_flag_q <= F_OCW2;
              else begin
                // d[4]=1 was already taken as ICW1, so only 00/01 reach here
                rw_flag_q <= F_OCW3;
                if (hold_d_q[1]) ris_q <= hold_d_q[0];
`ifdef RW_POLL_CMD_EN
                if (hold_d_q[2]) poll_pending_q <= 1'b1;
`endif
              end
            end
            default: illegal_q <= 1'b1;
          endcase
        end
      end
    end
  end

  // A read overlapping a synced write is suppressed; the write still commits.
  always_comb begin
    read_sel = 3'b000;
    if (!cs_s && !rd_s && wr_s) begin
      if (a0) read_sel = 3'b011;
`ifdef RW_POLL_CMD_EN
      else if (poll_pending_q) read_sel = 3'b111;
`endif
      else read_sel = {ris_q, 2'b01};
    end
  end

  assign rw_data    = rw_data_q;
  assign rw_flag    = rw_flag_q;
  assign init_done  = init_done_q;
  assign sngl       = sngl_q;
  assign ic4        = ic4_q;
  assign illegal_wr = illegal_q;

endmodule

// File: tb/tb_rw_command_sequencer.sv
// Scoreboard bench for rw_command_sequencer: a queue-based model of the ICW/OCW rules
// predicts each committed pulse; a negedge monitor pops and compares.
module tb_rw_command_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] rw_data;
  logic [2:0] rw_flag, read_sel;
  logic init_done, sngl, ic4, illegal_wr;

  rw_command_sequencer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .data_in(data_in), .rw_data(rw_data), .rw_flag(rw_flag), .read_sel(read_sel),
    .init_done(init_done), .sngl(sngl), .ic4(ic4), .illegal_wr(illegal_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int flag; bit ill; logic [7:0] data; bit init; bit sg; bit i4; int cyc;
  } exp_t;
  exp_t sb[$];

  // Model: the initialisation sequence is a list of ICW codes still owed.
  int   m_pend[$];
  bit   m_init, m_sngl, m_ic4, m_ris, m_poll;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_pend.delete();
    m_init = 0; m_sngl = 0; m_ic4 = 0; m_ris = 0; m_poll = 0; m_data = '0;
  endfunction

  function automatic void model_wr(bit a, logic [7:0] d, int ecyc);
    exp_t e;
    int code = -1;
    if (!a && d[4]) begin
      code = 0;
      m_sngl = d[1]; m_ic4 = d[0]; m_init = 0; m_ris = 0; m_poll = 0;
      m_pend.delete();
      m_pend.push_back(1);
      if (!m_sngl) m_pend.push_back(2);
      if (m_ic4)   m_pend.push_back(3);
    end else if (m_pend.size() > 0) begin
      if (a) begin
        code = m_pend.pop_front();
        if (m_pend.size() == 0) m_init = 1;
      end
    end else if (m_init) begin
      if (a) code = 4;
      else if (!d[3]) code = 5;
      else begin
        code = 6;
        if (d[1]) m_ris = d[0];
`ifdef RW_POLL_CMD_EN
        if (d[2]) m_poll = 1;
`endif
      end
    end
    if (code >= 0) m_data = d;
    e.flag = (code >= 0) ? code : 7;
    e.ill  = (code < 0);
    e.data = m_data; e.init = m_init; e.sg = m_sngl; e.i4 = m_ic4; e.cyc = ecyc;
    sb.push_back(e);
  endfunction

  function automatic int model_rd(bit a);
    int r;
    if (a) r = 3;
    else if (m_poll) begin r = 7; m_poll = 0; end
    else r = m_ris ? 5 : 1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (rw_flag != 3'd7 || illegal_wr)) begin
      if (sb.size() == 0) chk("unexpected_pulse", int'(rw_flag), 7);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("flag", int'(rw_flag), e.flag);
        chk("illegal_wr", int'(illegal_wr), int'(e.ill));
        chk("rw_data", int'(rw_data), int'(e.data));
        chk("init_done", int'(init_done), int'(e.init));
        chk("sngl", int'(sngl), int'(e.sg));
        chk("ic4", int'(ic4), int'(e.i4));
        chk("latency_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic cpu_wr(input bit a, input logic [7:0] d, input bit drop = 0,
                        input bit with_rd = 0);
    @(posedge clk); #1;
    a0 = a; data_in = d; cs_n = 0; wr_n = 0; rd_n = !with_rd;
    repeat (3) @(posedge clk); #1;
    if (with_rd) chk("rdwr_sel", int'(read_sel), 0);
    if (drop) begin cs_n = 1; repeat (3) @(posedge clk); #1; end
    wr_n = 1;
    if (!drop) model_wr(a, d, cyc + 3);
    repeat (3) @(posedge clk); #1;
    cs_n = 1; rd_n = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic cpu_rd(input bit a);
    @(posedge clk); #1;
    a0 = a; cs_n = 0; rd_n = 0;
    repeat (3) @(posedge clk); #1;
    chk("read_sel", int'(read_sel), model_rd(a));
    rd_n = 1;
    repeat (3) @(posedge clk); #1;
    cs_n = 1;
    repeat (3) @(posedge clk); #1;
    chk("read_sel_idle", int'(read_sel), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rw_data", int'(rw_data), 0);
    chk("rst_rw_flag", int'(rw_flag), 7);
    chk("rst_read_sel", int'(read_sel), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_sngl", int'(sngl), 0);
    chk("rst_ic4", int'(ic4), 0);
    chk("rst_illegal", int'(illegal_wr), 0);
  endtask

  logic [7:0] r;
  int op;

  initial begin
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk_reset_vals();
    rst_n = 1;
    repeat (4) @(posedge clk);

    // single mode, ICW4 needed: flags 0,1,3
    cpu_wr(0, 8'h13); cpu_wr(1, 8'h40); cpu_wr(1, 8'h01);
    // cascade mode: flags 0,1,2,3 then OCW1
    cpu_wr(0, 8'h11); cpu_wr(1, 8'h20); cpu_wr(1, 8'h04); cpu_wr(1, 8'h01);
    cpu_wr(1, 8'hFB);
    // read selection
    cpu_wr(0, 8'h0B); cpu_rd(0);
    cpu_wr(0, 8'h0A); cpu_rd(0);
    cpu_rd(1);
    cpu_wr(0, 8'h20);                 // OCW2
    cpu_wr(1, 8'h5A, 0, 1);           // simultaneous read and write
    // poll command
    cpu_wr(0, 8'h0C); cpu_rd(0); cpu_rd(0);
    // restart mid-READY, then discard in WAIT_ICW2
    cpu_wr(0, 8'h12);
    cpu_wr(0, 8'h20);
    cpu_wr(1, 8'h33, 1);              // cs dropped early: silent
    cpu_wr(1, 8'h44);                 // ICW2, single without ICW4 -> READY

    // reset while a write strobe is held low
    @(posedge clk); #1;
    a0 = 1; data_in = 8'h77; cs_n = 0; wr_n = 0;
    repeat (3) @(posedge clk); #1;
    rst_n = 0; model_reset();
    #2; chk_reset_vals();
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk); #1;
    wr_n = 1;
    repeat (4) @(posedge clk); #1;
    cs_n = 1;
    repeat (3) @(posedge clk);
    cpu_wr(1, 8'h01);                 // still WAIT_ICW1: discarded

    // randomized traffic
    for (int it = 0; it < 8; it++) begin
      r = 8'($urandom); r[4] = 1; cpu_wr(0, r);
      for (int k = 0; k < 10; k++) begin
        op = $urandom_range(0, 4);
        r = 8'($urandom);
        case (op)
          0, 1: cpu_wr(1, r);
          2: begin r[4] = 0; cpu_wr(0, r); end
          3: cpu_rd(r[0]);
          default: begin r[4] = (r[7:5] == 3'd0); cpu_wr(0, r); end
        endcase
      end
    end

    repeat (10) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
